// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the FIFO controller slice.
// Holds the clog2 width function and the legal DEPTH range.
package fifo_pkg;

    localparam int DEPTH_MIN = 2;
    localparam int DEPTH_MAX = 1024;

    // Ceiling log2; used for pointer and occupancy widths.
    function automatic int clog2(input int value);
        int width;
        width = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << width) < value) begin
                width = width + 1;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/fifo_ptr_wrap.sv
// FIFO pointer: advances on inc, wraps DEPTH-1 -> 0, clr forces 0.
// Ports: clk, reset_n (async low), inc, clr, ptr (current pointer).
module fifo_ptr_wrap
    import fifo_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int W     = clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] ptr
);

    // Explicit compare so non-power-of-two depths wrap correctly.
    localparam logic [W-1:0] LAST = W'(DEPTH - 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == LAST) ? '0 : ptr + W'(1);
        end
    end

endmodule

// File: rtl/sync_fifo_ctrl_v2.sv
// Synchronous FIFO controller: pointers, occupancy, status and sticky errors.
// Ports: clk, reset_n, wr/rd/flush/clr_err, af/ae thresholds in;
// flags, count, RAM addresses, wr_en/rd_en strobes, overflow/underflow out.
module sync_fifo_ctrl_v2
    import fifo_pkg::*;
#(
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = clog2(DEPTH),
    localparam int CNT_W  = clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr,
    input  logic              rd,
    input  logic              flush,
    input  logic              clr_err,
    input  logic [CNT_W-1:0]  af_level,
    input  logic [CNT_W-1:0]  ae_level,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CNT_W-1:0]  count,
    output logic [ADDR_W-1:0] w_addr,
    output logic [ADDR_W-1:0] r_addr,
    output logic              wr_en,
    output logic              rd_en,
    output logic              overflow,
    output logic              underflow
);

    if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
        $error("sync_fifo_ctrl_v2: DEPTH out of range");
    end

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [CNT_W-1:0] count_next;
    logic             ovf_set;
    logic             udf_set;

    // A write into a full FIFO is allowed when a pop frees the slot.
    assign wr_en = wr & ~flush & (~full | rd);
    assign rd_en = rd & ~flush & ~empty;

    assign ovf_set = wr & ~wr_en & ~flush;
    assign udf_set = rd & ~rd_en & ~flush;

    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else begin
            count_next = count + CNT_W'(wr_en) - CNT_W'(rd_en);
        end
    end

    fifo_ptr_wrap #(.DEPTH(DEPTH)) u_wptr (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (wr_en),
        .clr     (flush),
        .ptr     (w_addr)
    );

    fifo_ptr_wrap #(.DEPTH(DEPTH)) u_rptr (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (rd_en),
        .clr     (flush),
        .ptr     (r_addr)
    );

    // Flags come from count_next so they move on the same edge as count,
    // and are refreshed every cycle so threshold edits apply without traffic.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            count        <= count_next;
            full         <= (count_next == DEPTH_C);
            empty        <= (count_next == '0);
            almost_full  <= (count_next >= af_level);
            almost_empty <= (count_next <= ae_level);
            // A fresh error outranks a same-cycle clear.
            overflow     <= ovf_set | (overflow & ~clr_err);
            underflow    <= udf_set | (underflow & ~clr_err);
        end
    end

endmodule

// File: doc/sync_fifo_ctrl_v2.md
SYNC_FIFO_CTRL_V2 -- requirements
Module: sync_fifo_ctrl_v2

Interface
REQ-001 SHALL have parameter: DEPTH, default 16, number of FIFO entries, any integer 2..1024 (power of two not required).
REQ-002 SHALL derive localparams ADDR_W = clog2(DEPTH) and CNT_W = clog2(DEPTH+1).
REQ-003 SHALL have port: clk  input  1  single clock, all logic rising-edge.
REQ-004 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports: wr  input  1  write request; rd  input  1  read request.
REQ-006 SHALL have port: flush  input  1  synchronous clear of FIFO contents.
REQ-007 SHALL have port: clr_err  input  1  clears sticky error flags.
REQ-008 SHALL have ports: af_level  input  CNT_W  almost-full threshold; ae_level  input  CNT_W  almost-empty threshold.
REQ-009 SHALL have ports: full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-010 SHALL have port: count  output  CNT_W  current occupancy.
REQ-011 SHALL have ports: w_addr, r_addr  output  ADDR_W  RAM write/read addresses (current pointers).
REQ-012 SHALL have ports: wr_en  output  1  combinational qualified write strobe to RAM; rd_en  output  1  combinational qualified read (pop) strobe.
REQ-013 SHALL have ports: overflow, underflow  output  1 each  sticky error flags.

Function
REQ-014 Accept rules (combinational): wr_en = wr & ~flush & (~full | rd); rd_en = rd & ~flush & ~empty.
REQ-015 wr & rd when empty: write accepted, read rejected, underflow set.
REQ-016 wr & rd when full: both accepted; count unchanged; full stays 1.
REQ-017 Each pointer advances by 1 on its accepted strobe and wraps DEPTH-1 -> 0 (explicit compare, not natural overflow).
REQ-018 count_next = count + wr_en - rd_en; count never exceeds DEPTH nor goes below 0.
REQ-019 All flags registered, computed from count_next, so they change on the same edge as count: full = (count == DEPTH), empty = (count == 0), almost_full = (count >= af_level), almost_empty = (count <= ae_level).
REQ-020 Threshold changes take effect on the next clock edge, even without wr/rd activity.
REQ-021 overflow sets on wr & ~wr_en & ~flush; underflow sets on rd & ~rd_en & ~flush; both sticky.
REQ-022 clr_err clears both error flags; a new error in the same cycle wins (flag stays 1).
REQ-023 flush has highest priority: next edge pointers=0, count=0, empty=1, full=0; wr/rd that cycle ignored, no error set; error flags untouched.
REQ-024 Latency: accepted write visible in count/empty on the following edge; no combinational path from wr/rd to any flag output.

Reset
REQ-025 On reset_n low (asynchronous): w_addr=0, r_addr=0, count=0, empty=1, full=0, overflow=0, underflow=0.
REQ-026 almost_empty resets to 1, almost_full resets to 0 regardless of threshold inputs; flags re-evaluate against thresholds from the first edge after release.
REQ-027 Reset mid-operation discards all contents; release is synchronous-safe (deassertion sampled on clk).

Structure
REQ-028 Shared package fifo_pkg SHALL hold clog2-based width helper function and the DEPTH range limits.
REQ-029 Pointer increment-with-wrap SHALL be one sub-module fifo_ptr_wrap (params DEPTH; ports clk, reset_n, inc, clr, ptr), instantiated twice.

Verification (DEPTH=6, af_level=5, ae_level=1)
REQ-030 After reset, 6 writes -> count 0..6, full=1 at count 6, almost_full=1 from count 5, w_addr sequence 0,1,2,3,4,5,0.
REQ-031 Full, then 7th write alone -> wr_en=0, overflow=1, count stays 6; clr_err next cycle -> overflow=0.
REQ-032 Empty, wr&rd together -> count 1, r_addr 0, underflow=1; full, wr&rd -> count 6, both pointers +1 with wrap.
REQ-033 count=4, flush & wr asserted -> next edge count 0, empty=1, pointers 0, overflow/underflow unchanged.
REQ-034 count=3, change af_level 5->3 without traffic -> almost_full=1 after one edge.
REQ-035 reset_n pulsed low mid-burst at count 4 -> outputs immediately at reset values, no clock required.
